// File: rtl/spimem_arb.sv
// Two-port round-robin arbiter in front of a single SPI flash read port.
// Grants are held for a whole burst; contended bursts are optionally preempted after MAX_BURST beats.
module spimem_arb #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_valid,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_valid,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] spimem_addr,
  output logic              spimem_valid,
  input  logic              spimem_ready,
  input  logic [31:0]       spimem_rdata,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_G0, ST_G1, ST_SWITCH} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LP_CNT_PRE = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

  state_t           r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic w_g0;
  logic w_g1;
  logic w_own_valid;
  logic w_other_valid;
  logic w_preempt;

  assign w_g0          = (r_state == ST_G0);
  assign w_g1          = (r_state == ST_G1);
  assign w_own_valid   = w_g0 ? m0_valid : m1_valid;
  assign w_other_valid = w_g0 ? m1_valid : m0_valid;
  assign w_preempt     = (MAX_BURST != 0) && spimem_ready && (r_cnt == LP_CNT_PRE) && w_other_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A tie goes to the port that was not served last.
          if (m0_valid && (!m1_valid || r_last)) begin
            r_state <= ST_G0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
          end else if (m1_valid) begin
            r_state <= ST_G1;
            r_last  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_G0, ST_G1: begin
          // Release wins over preemption when both happen on the same edge.
          if (!w_own_valid) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (spimem_ready) begin
            if (r_cnt != LP_CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            if (w_preempt) r_state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          r_cnt <= '0;
          if (r_last) begin
            r_state <= ST_G0;
            r_last  <= 1'b0;
          end else begin
            r_state <= ST_G1;
            r_last  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spimem_addr  = w_g0 ? m0_addr : (w_g1 ? m1_addr : '0);
  assign spimem_valid = (w_g0 & m0_valid) | (w_g1 & m1_valid);
  assign m0_ready     = spimem_ready & w_g0;
  assign m1_ready     = spimem_ready & w_g1;
  assign m0_rdata     = spimem_rdata;
  assign m1_rdata     = spimem_rdata;
  assign gnt          = {w_g1, w_g0};

endmodule

// File: tb/tb_spimem_arb.sv
// Scoreboard bench for spimem_arb: two burst masters, a flash model with random beat latency,
// per-port expected-data queues and a per-cycle trace of grant/valid/address/ready.
module tb_spimem_arb;
  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_addr, m1_addr, spimem_addr;
  logic          m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata, spimem_rdata;
  logic          spimem_valid, spimem_ready;
  logic [1:0]    gnt;

  always #5 clk = ~clk;

  spimem_arb #(.ADDR_W(AW), .MAX_BURST(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .spimem_addr(spimem_addr), .spimem_valid(spimem_valid),
    .spimem_ready(spimem_ready), .spimem_rdata(spimem_rdata), .gnt(gnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] f_data(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'hC3, a};
  endfunction

  logic [31:0]   sb0[$], sb1[$];
  logic [1:0]    tr[$], rtr[$];
  logic          vtr[$];
  logic [AW-1:0] atr[$];

  int            m0_left, m1_left, n0, n1, fl_cnt, fl_wait;
  logic [AW-1:0] m0_a, m1_a;
  bit            early0, early1, fl_en;

  logic [1:0]    s_gnt;
  logic          s_sv, s_sr, s_r0, s_r1;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_d0, s_d1;

  // Sample at negedge, then drive the next window just after the posedge.
  task automatic cycle();
    @(negedge clk);
    s_gnt = gnt; s_sv = spimem_valid; s_sr = spimem_ready; s_addr = spimem_addr;
    s_r0 = m0_ready; s_r1 = m1_ready; s_d0 = m0_rdata; s_d1 = m1_rdata;
    tr.push_back(s_gnt); vtr.push_back(s_sv); atr.push_back(s_addr); rtr.push_back({s_r1, s_r0});
    @(posedge clk); #1;
    if (s_r0 === 1'b1) begin
      if (sb0.size() == 0) check("m0_spurious_ready", 32'(s_r0), 32'd0);
      else check("m0_rdata", s_d0, sb0.pop_front());
      n0++;
      if (m0_left > 0) m0_left--;
      m0_a = m0_a + AW'(4);
      if (m0_left > 0) begin m0_addr = m0_a; sb0.push_back(f_data(m0_a)); end
      else m0_valid = 1'b0;
    end
    if (s_r1 === 1'b1) begin
      if (sb1.size() == 0) check("m1_spurious_ready", 32'(s_r1), 32'd0);
      else check("m1_rdata", s_d1, sb1.pop_front());
      n1++;
      if (m1_left > 0) m1_left--;
      m1_a = m1_a + AW'(4);
      if (m1_left > 0) begin m1_addr = m1_a; sb1.push_back(f_data(m1_a)); end
      else m1_valid = 1'b0;
    end
    if (fl_en) begin
      spimem_ready = 1'b0;
      spimem_rdata = $urandom;
      if (s_sv === 1'b1 && s_sr !== 1'b1) begin
        if (fl_cnt >= fl_wait) begin
          spimem_ready = 1'b1;
          spimem_rdata = f_data(s_addr);
          fl_cnt = 0;
          fl_wait = $urandom_range(0, 2);
          if (early0 && s_gnt == 2'b01 && m0_left == 1) m0_valid = 1'b0;
          if (early1 && s_gnt == 2'b10 && m1_left == 1) m1_valid = 1'b0;
        end else fl_cnt++;
      end else if (s_sv !== 1'b1) fl_cnt = 0;
    end
  endtask

  task automatic start0(input logic [AW-1:0] a, input int n);
    m0_a = a; m0_addr = a; m0_left = n; m0_valid = 1'b1; sb0.push_back(f_data(a));
  endtask

  task automatic start1(input logic [AW-1:0] a, input int n);
    m1_a = a; m1_addr = a; m1_left = n; m1_valid = 1'b1; sb1.push_back(f_data(a));
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; m0_addr = '0; m1_addr = '0;
    m0_left = 0; m1_left = 0; early0 = 0; early1 = 0; fl_en = 0;
    spimem_ready = 1'b1; spimem_rdata = 32'hDEAD_BEEF;
    cycle(); cycle();
    check("rst_gnt", 32'(s_gnt), 32'd0);
    check("rst_valid", 32'(s_sv), 32'd0);
    check("rst_addr", 32'(s_addr), 32'd0);
    check("rst_ready", 32'({s_r1, s_r0}), 32'd0);
    reset = 1'b0; spimem_ready = 1'b0; fl_en = 1; fl_cnt = 0; fl_wait = 0;
    sb0.delete(); sb1.delete(); tr.delete(); vtr.delete(); atr.delete(); rtr.delete();
    n0 = 0; n1 = 0;
  endtask

  task automatic run_done(input int maxc, input string tag);
    int c;
    c = 0;
    while ((m0_left > 0 || m1_left > 0) && c < maxc) begin cycle(); c++; end
    check({tag, "_done"}, 32'(m0_left + m1_left), 32'd0);
    repeat (3) cycle();
  endtask

  task automatic wait_gnt(input logic [1:0] g, input int maxc, input string tag);
    int c;
    c = 0;
    do begin cycle(); c++; end while (s_gnt !== g && c < maxc);
    check({tag, "_wait_gnt"}, 32'(s_gnt), 32'(g));
  endtask

  function automatic int find(input logic [1:0] v, input int from);
    for (int i = from; i < tr.size(); i++) if (tr[i] == v) return i;
    return -1;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, k, c;

    // Single uncontended 4-beat burst.
    do_reset();
    start0(24'h000100, 4);
    cycle(); check("t1_lat_gnt", 32'(s_gnt), 32'd0);
    cycle(); check("t1_gnt", 32'(s_gnt), 32'd1);
    check("t1_addr", 32'(s_addr), 32'h100);
    check("t1_valid", 32'(s_sv), 32'd1);
    run_done(60, "t1");
    check("t1_n0", n0, 4);
    check("t1_n1", n1, 0);
    check("t1_release", 32'(tr[tr.size()-1]), 32'd0);

    // Simultaneous requests after reset: port 0 first, IDLE gap, then port 1.
    do_reset();
    start0(24'h000200, 2);
    start1(24'h000300, 2);
    run_done(80, "t2");
    j = find(2'b01, 0);
    check("t2_first_gnt", 32'(j >= 0), 32'd1);
    j = find(2'b10, 0);
    check("t2_g1_found", 32'(j >= 2), 32'd1);
    if (j >= 2) begin
      check("t2_gap", 32'(tr[j-1]), 32'd0);
      check("t2_before_gap", 32'(tr[j-2]), 32'd1);
    end
    check("t2_n0", n0, 2);
    check("t2_n1", n1, 2);

    // Preemption after 8 beats, then regrant of port 0 at its current address.
    do_reset();
    start0(24'h001000, 20);
    c = 0;
    while (n0 < 3 && c < 100) begin cycle(); c++; end
    check("t3_n0_pre", 32'(n0 >= 3), 32'd1);
    start1(24'h002000, 3);
    run_done(300, "t3");
    j = find(2'b10, 0);
    check("t3_g1_found", 32'(j >= 2), 32'd1);
    if (j >= 2) begin
      check("t3_switch_gnt", 32'(tr[j-1]), 32'd0);
      check("t3_switch_valid", 32'(vtr[j-1]), 32'd0);
      check("t3_before_switch", 32'(tr[j-2]), 32'd1);
      c = 0;
      for (int i = 0; i < j; i++) c += int'(rtr[i][0]);
      check("t3_beats_before_preempt", c, 8);
      k = find(2'b01, j);
      check("t3_regrant_found", 32'(k >= 1), 32'd1);
      if (k >= 1) begin
        check("t3_regrant_gap", 32'(tr[k-1]), 32'd0);
        check("t3_regrant_addr", 32'(atr[k]), 32'h001020);
      end
    end
    check("t3_n0", n0, 20);
    check("t3_n1", n1, 3);

    // Long uncontended stream: grant never drops.
    do_reset();
    start0(24'h003000, 20);
    run_done(300, "t4");
    j = find(2'b01, 0);
    k = 0;
    for (int i = 0; i < rtr.size(); i++) if (rtr[i][0]) k = i;
    c = 0;
    if (j >= 0) for (int i = j; i <= k; i++) if (tr[i] != 2'b01) c++;
    check("t4_grant_gaps", c, 0);
    check("t4_n0", n0, 20);

    // Last served was port 0, so a tie now goes to port 1.
    start0(24'h007000, 1);
    start1(24'h007100, 1);
    cycle(); cycle();
    check("t4_tie_rr", 32'(s_gnt), 32'd2);
    run_done(60, "t4b");

    // Port 1 drops valid on its 8th beat while port 0 waits: release path.
    do_reset();
    early1 = 1;
    start1(24'h005000, 8);
    wait_gnt(2'b10, 20, "t5");
    start0(24'h006000, 2);
    run_done(200, "t5");
    k = find(2'b01, 0);
    check("t5_g0_found", 32'(k >= 2), 32'd1);
    if (k >= 2) begin
      check("t5_gap", 32'(tr[k-1]), 32'd0);
      check("t5_last_g1", 32'(tr[k-2]), 32'd2);
      check("t5_last_beat", 32'(rtr[k-2]), 32'd2);
    end
    check("t5_n1", n1, 8);
    check("t5_n0", n0, 2);

    // Reset with a port-1 beat outstanding, then a stray ready.
    do_reset();
    start1(24'h004000, 4);
    wait_gnt(2'b10, 20, "t6");
    fl_en = 0; spimem_ready = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0; m1_valid = 1'b0; m1_left = 0; sb1.delete(); spimem_ready = 1'b1;
    cycle();
    check("t6_gnt", 32'(s_gnt), 32'd0);
    check("t6_valid", 32'(s_sv), 32'd0);
    check("t6_stray_ready", 32'({s_r1, s_r0}), 32'd0);
    cycle();
    check("t6_stray_ready2", 32'({s_r1, s_r0}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
